// File: rtl/washing_machine_connect.sv
// ---------------------------------------------------------------------------
// washing_machine_connect
//   Wash-cycle sequencer. A start request with a non-empty load selector runs
//   fill, wash, drain, rinse-fill, rinse, drain and spin, then parks in DONE
//   until start is released. Load-dependent phases scale with the load size
//   latched at start. An open door pauses the active phase: the timer freezes
//   and all actuators are forced off until the door closes again.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   door     in   1 = door open
//   start    in   start request (level), honoured in IDLE/DONE only
//   load     in   load size 1..3, 0 = empty (start refused)
//   agitator out  agitator enable
//   motor    out  drum motor enable
//   pump     out  drain pump enable
//   speed    out  0 = wash speed, 1 = spin speed
//   water    out  fill valve enable
// ---------------------------------------------------------------------------
module washing_machine_connect #(
    parameter int FILL_T  = 4,
    parameter int WASH_T  = 8,
    parameter int RINSE_T = 6,
    parameter int DRAIN_T = 4,
    parameter int SPIN_T  = 8,
    parameter int TW      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door,
    input  logic       start,
    input  logic [1:0] load,
    output logic       agitator,
    output logic       motor,
    output logic       pump,
    output logic       speed,
    output logic       water
);

    typedef enum logic [3:0] {
        IDLE, FILL, WASH, DRAIN1, RFILL, RINSE, DRAIN2, SPIN, DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic [1:0]    lat;
    logic [1:0]    l_eff;
    logic          active;
    logic          paused;

    function automatic logic is_active(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    // Phase length in cycles; load-scaled phases use the given load size.
    function automatic logic [TW-1:0] phase_len(input state_t s, input logic [1:0] l);
        logic [TW-1:0] lw;
        logic [TW-1:0] len;
        lw = {{(TW-2){1'b0}}, l};
        case (s)
            FILL, RFILL: len = TW'(FILL_T) * lw;
            WASH:        len = TW'(WASH_T) * lw;
            RINSE:       len = TW'(RINSE_T) * lw;
            DRAIN1,
            DRAIN2:      len = TW'(DRAIN_T);
            SPIN:        len = TW'(SPIN_T);
            default:     len = '0;
        endcase
        return len;
    endfunction

    assign active = is_active(state);
    assign paused = door && active;
    // The load input is only consulted on the IDLE->FILL edge; afterwards the
    // latched copy governs every scaled phase.
    assign l_eff  = (state == IDLE) ? load : lat;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && !door && (load != 2'd0)) state_n = FILL;
            FILL:    if (!door && timer == '0) state_n = WASH;
            WASH:    if (!door && timer == '0) state_n = DRAIN1;
            DRAIN1:  if (!door && timer == '0) state_n = RFILL;
            RFILL:   if (!door && timer == '0) state_n = RINSE;
            RINSE:   if (!door && timer == '0) state_n = DRAIN2;
            DRAIN2:  if (!door && timer == '0) state_n = SPIN;
            SPIN:    if (!door && timer == '0) state_n = DONE;
            DONE:    if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Phase timer: reloads on every phase change, counts down only with the
    // door closed, so a pause simply holds the remaining count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state_n != state) begin
            if (is_active(state_n)) timer <= phase_len(state_n, l_eff) - TW'(1);
            else                    timer <= '0;
        end else if (active && !door && timer != '0) begin
            timer <= timer - TW'(1);
        end
    end

    // Load latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 lat <= 2'd0;
        else if (state == IDLE && state_n == FILL) lat <= load;
    end

    // Output decode
    always_comb begin
        water    = 1'b0;
        agitator = 1'b0;
        motor    = 1'b0;
        speed    = 1'b0;
        pump     = 1'b0;
        if (!paused) begin
            case (state)
                FILL, RFILL: water = 1'b1;
                WASH, RINSE: begin
                    agitator = 1'b1;
                    motor    = 1'b1;
                end
                DRAIN1, DRAIN2: pump = 1'b1;
                SPIN: begin
                    motor = 1'b1;
                    speed = 1'b1;
                    pump  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_washing_machine_connect.sv
module tb_washing_machine_connect;

    logic       clk = 1'b0;
    logic       rst;
    logic       door;
    logic       start;
    logic [1:0] load;
    logic       agitator, motor, pump, speed, water;

    int checks = 0;
    int errors = 0;

    // Expected output vector {water, agitator, motor, speed, pump}
    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] W  = 5'b10000;
    localparam logic [4:0] AG = 5'b01100;
    localparam logic [4:0] PU = 5'b00001;
    localparam logic [4:0] SP = 5'b00111;

    logic [4:0] sb[$];

    washing_machine_connect dut (
        .clk(clk), .rst(rst), .door(door), .start(start), .load(load),
        .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
        .water(water)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {water, agitator, motor, speed, pump};
    endfunction

    task automatic check_now(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = outs();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: queue the expectation for the state after the coming edge,
    // then compare at the following falling edge.
    task automatic cyc(input string tag, input logic [4:0] e);
        logic [4:0] got;
        logic [4:0] exp;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = outs();
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic phase(input string tag, input int n, input logic [4:0] e);
        for (int i = 0; i < n; i++) cyc(tag, e);
    endtask

    initial begin
        rst = 1'b1; door = 1'b0; start = 1'b0; load = 2'd0;
        #12;
        check_now("reset_state", Z);
        @(negedge clk);
        rst = 1'b0;
        phase("idle_after_reset", 3, Z);

        // Normal cycle, load 1, start held
        start = 1'b1; load = 2'd1;
        phase("l1_fill", 4, W);
        phase("l1_wash", 8, AG);
        phase("l1_drain1", 4, PU);
        phase("l1_rfill", 4, W);
        phase("l1_rinse", 6, AG);
        phase("l1_drain2", 4, PU);
        phase("l1_spin", 8, SP);
        phase("l1_done_hold", 4, Z);
        start = 1'b0;
        cyc("l1_done_to_idle", Z);

        // Restart from IDLE with load 3; load changed mid-cycle is ignored
        start = 1'b1; load = 2'd3;
        phase("l3_fill_a", 5, W);
        load = 2'd1;
        phase("l3_fill_b", 7, W);
        phase("l3_wash", 24, AG);
        phase("l3_drain1", 4, PU);
        phase("l3_rfill", 12, W);
        phase("l3_rinse", 18, AG);
        phase("l3_drain2", 4, PU);
        phase("l3_spin", 8, SP);
        phase("l3_done", 2, Z);
        start = 1'b0;
        phase("l3_idle", 2, Z);

        // Door opened during wash
        start = 1'b1; load = 2'd1;
        phase("dr_fill", 4, W);
        phase("dr_wash_pre", 3, AG);
        door = 1'b1;
        phase("dr_paused", 5, Z);
        door = 1'b0;
        phase("dr_wash_post", 5, AG);
        phase("dr_drain1", 4, PU);
        phase("dr_rfill", 4, W);
        phase("dr_rinse", 6, AG);
        phase("dr_drain2", 4, PU);
        phase("dr_spin", 8, SP);
        start = 1'b0;
        phase("dr_idle", 2, Z);

        // Asynchronous reset in the middle of wash
        start = 1'b1; load = 2'd2;
        phase("rs_fill", 8, W);
        phase("rs_wash", 5, AG);
        #2 rst = 1'b1;
        #1 check_now("rs_async_zero", Z);
        @(negedge clk);
        check_now("rs_held", Z);
        start = 1'b0;
        rst = 1'b0;
        phase("rs_idle", 4, Z);

        // Empty load never starts
        start = 1'b1; load = 2'd0;
        phase("load0_idle", 10, Z);

        // Door open blocks start; closing it starts on the next edge
        door = 1'b1; load = 2'd2;
        phase("door_idle", 4, Z);
        door = 1'b0;
        phase("door_fill", 8, W);
        phase("door_wash", 1, AG);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
